regfile_param_dual: RTL and testbench

//  Parametrised 2-read/1-write register file. Successor of the fixed 16x4 dual-port regfile.

---
 rtl/regfile_param_dual_pkg.sv | 6 +
 rtl/regfile_param_dual_clear_fsm.sv | 42 ++++
 rtl/regfile_param_dual.sv | 74 +++++++
 tb/tb_regfile_param_dual.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_param_dual_pkg.sv
// regfile_param_dual_pkg: clear-FSM state encoding and default geometry shared by the register file blocks
package regfile_param_dual_pkg;
  typedef enum logic {RF_ST_CLEAR = 1'b0, RF_ST_IDLE = 1'b1} rf_state_e;
  localparam int RF_WIDTH = 4;
  localparam int RF_DEPTH = 16;
endpackage

// File: rtl/regfile_param_dual_clear_fsm.sv
// regfile_param_dual_clear_fsm: clear sweep sequencer owning state, clr_ptr and busy
module regfile_param_dual_clear_fsm
  import regfile_param_dual_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  rf_state_e state, state_nx;
  logic [AW-1:0] clr_ptr, clr_ptr_nx;
  // state and sweep pointer registers; reset always restarts the sweep at entry 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RF_ST_CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
    end
  end
  // sweep one entry per cycle, leave after the last entry; idle only listens to clr_req
  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    if (state == RF_ST_CLEAR) begin
      clr_ptr_nx = (clr_ptr == AW'(DEPTH - 1)) ? '0 : clr_ptr + AW'(1);
      state_nx   = (clr_ptr == AW'(DEPTH - 1)) ? RF_ST_IDLE : RF_ST_CLEAR;
    end else if (clr_req) begin
      state_nx   = RF_ST_CLEAR;
      clr_ptr_nx = '0;
    end
  end
  assign busy     = (state == RF_ST_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_ptr;
endmodule

// File: rtl/regfile_param_dual.sv
// regfile_param_dual: 2-read/1-write register file with registered reads and clear sweep (option: REGFILE_PARAM_DUAL_BYPASS_EN)
module regfile_param_dual
  import regfile_param_dual_pkg::*;
#(
  parameter int WIDTH = RF_WIDTH,
  parameter int DEPTH = RF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_req,
  output logic             busy,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en1,
  input  logic [AW-1:0]    rd_addr1,
  output logic [WIDTH-1:0] rd_data1,
  output logic             rd_valid1,
  input  logic             rd_en2,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data2,
  output logic             rd_valid2
);
`ifdef REGFILE_PARAM_DUAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [WIDTH-1:0] mem [DEPTH];
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             wr_ok, ok1, ok2;
  logic [WIDTH-1:0] nx1, nx2;
  regfile_param_dual_clear_fsm #(.DEPTH(DEPTH)) u_clr (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );
  // a clear request in the same cycle beats a user write; out-of-range addresses read as zero
  always_comb begin
    wr_ok = !busy && !clr_req && wr_en && (32'(wr_addr) < DEPTH);
    ok1   = !busy && rd_en1;
    ok2   = !busy && rd_en2;
    nx1   = (!ok1 || 32'(rd_addr1) >= DEPTH) ? '0 :
            (BYPASS && wr_ok && wr_addr == rd_addr1) ? wr_data : mem[rd_addr1];
    nx2   = (!ok2 || 32'(rd_addr2) >= DEPTH) ? '0 :
            (BYPASS && wr_ok && wr_addr == rd_addr2) ? wr_data : mem[rd_addr2];
  end
  // array write mux: the sweep overrides user writes, nothing is written while reset is held
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_we) mem[clr_addr] <= '0;
      else if (wr_ok) mem[wr_addr] <= wr_data;
    end
  end
  // registered read ports; data is forced to zero whenever valid is low
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid1 <= 1'b0;
      rd_valid2 <= 1'b0;
      rd_data1  <= '0;
      rd_data2  <= '0;
    end else begin
      rd_valid1 <= ok1;
      rd_valid2 <= ok2;
      rd_data1  <= nx1;
      rd_data2  <= nx2;
    end
  end
endmodule

// File: tb/tb_regfile_param_dual.sv
// tb_regfile_param_dual: randomized self-check of DEPTH=16 and DEPTH=10 instances against a behavioural model
module tb_regfile_param_dual;
  logic clk = 1'b0, reset = 1'b1, clr_req = 1'b0, wr_en = 1'b0, rd_en1 = 1'b0, rd_en2 = 1'b0;
  logic [3:0] wr_addr = '0, wr_data = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic       busy_o [2], v1 [2], v2 [2];
  logic [3:0] d1 [2], d2 [2];
  int errors = 0, checks = 0;
`ifdef REGFILE_PARAM_DUAL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  int dep [2] = '{16, 10};
  logic [3:0] m [2][16];
  int left [2];
  logic       e_busy [2], e_v1 [2], e_v2 [2];
  logic [3:0] e_d1 [2], e_d2 [2];

  always #5 clk = ~clk;

  regfile_param_dual #(.WIDTH(4), .DEPTH(16)) u16 (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_o[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(d1[0]), .rd_valid1(v1[0]),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(d2[0]), .rd_valid2(v2[0])
  );
  regfile_param_dual #(.WIDTH(4), .DEPTH(10)) u10 (
    .clk(clk), .reset(reset), .clr_req(clr_req), .busy(busy_o[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_data1(d1[1]), .rd_valid1(v1[1]),
    .rd_en2(rd_en2), .rd_addr2(rd_addr2), .rd_data2(d2[1]), .rd_valid2(v2[1])
  );

  function automatic logic [3:0] rd_model(int i, logic en, logic [3:0] a, logic ok);
    if (!en || a >= dep[i]) return 4'h0;
    if (BYP && ok && a == wr_addr) return wr_data;
    return m[i][a];
  endfunction

  task automatic step();
    logic ok;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        left[i] = dep[i];
        e_v1[i] = 0; e_v2[i] = 0; e_d1[i] = 0; e_d2[i] = 0;
      end else if (left[i] > 0) begin
        m[i][dep[i] - left[i]] = 4'h0;
        left[i]--;
        e_v1[i] = 0; e_v2[i] = 0; e_d1[i] = 0; e_d2[i] = 0;
      end else begin
        ok = wr_en && !clr_req && wr_addr < dep[i];
        e_v1[i] = rd_en1; e_d1[i] = rd_model(i, rd_en1, rd_addr1, ok);
        e_v2[i] = rd_en2; e_d2[i] = rd_model(i, rd_en2, rd_addr2, ok);
        if (ok) m[i][wr_addr] = wr_data;
        if (clr_req) left[i] = dep[i];
      end
      e_busy[i] = left[i] > 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr_req = 0; wr_en = 0; rd_en1 = 0; rd_en2 = 0;
  endtask

  task automatic test_reset();
    int n [2];
    reset = 1; idle();
    step(); step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy_o[i], v1[i], d1[i], v2[i], d2[i]} !== {1'b1, 1'b0, 4'h0, 1'b0, 4'h0}) begin
        errors++; $display("FAIL reset inst%0d: got b=%b v1=%b d1=%h v2=%b d2=%h exp b=1 v=0 d=0", i, busy_o[i], v1[i], d1[i], v2[i], d2[i]);
      end
    end
    reset = 0;
    n = '{-1, -1};
    for (int k = 1; k <= 20; k++) begin
      step();
      for (int i = 0; i < 2; i++) if (!busy_o[i] && n[i] < 0) n[i] = k;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (n[i] != dep[i]) begin
        errors++; $display("FAIL reset_busy_len inst%0d: got %0d cycles exp %0d", i, n[i], dep[i]);
      end
    end
    for (int a = 0; a < 16; a++) begin
      rd_en1 = 1; rd_addr1 = 4'(a); rd_en2 = 1; rd_addr2 = 4'(15 - a);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({v1[i], d1[i], v2[i], d2[i]} !== {1'b1, 4'h0, 1'b1, 4'h0}) begin
          errors++; $display("FAIL reset_read inst%0d a=%0d: got v1=%b d1=%h v2=%b d2=%h exp v=1 d=0", i, a, v1[i], d1[i], v2[i], d2[i]);
        end
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1; wr_addr = 4'd5; wr_data = 4'hA;
    step();
    wr_en = 0; rd_en1 = 1; rd_addr1 = 4'd5; rd_en2 = 1; rd_addr2 = 4'd5;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({v1[i], d1[i], v2[i], d2[i]} !== {1'b1, 4'hA, 1'b1, 4'hA}) begin
        errors++; $display("FAIL write_read inst%0d: got v1=%b d1=%h v2=%b d2=%h exp v=1 d=a", i, v1[i], d1[i], v2[i], d2[i]);
      end
    end
    idle();
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({v1[i], d1[i], v2[i], d2[i]} !== {1'b0, 4'h0, 1'b0, 4'h0}) begin
        errors++; $display("FAIL read_off inst%0d: got v1=%b d1=%h v2=%b d2=%h exp v=0 d=0", i, v1[i], d1[i], v2[i], d2[i]);
      end
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1; wr_addr = 4'd3; wr_data = 4'h2;
    step();
    wr_data = 4'h7; rd_en1 = 1; rd_addr1 = 4'd3;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({v1[i], d1[i]} !== {1'b1, (BYP ? 4'h7 : 4'h2)}) begin
        errors++; $display("FAIL bypass inst%0d: got v1=%b d1=%h exp v=1 d=%h", i, v1[i], d1[i], BYP ? 4'h7 : 4'h2);
      end
    end
    wr_en = 0;
    step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({v1[i], d1[i]} !== {1'b1, 4'h7}) begin
        errors++; $display("FAIL bypass_after inst%0d: got v1=%b d1=%h exp v=1 d=7", i, v1[i], d1[i]);
      end
    end
    idle();
  endtask

  task automatic test_clear();
    int n [2];
    idle();
    for (int a = 0; a < 16; a++) begin
      wr_en = 1; wr_addr = 4'(a); wr_data = 4'($urandom_range(1, 15));
      step();
    end
    clr_req = 1; wr_en = 1; wr_addr = 4'd0; wr_data = 4'hF;
    step();
    idle();
    n = '{-1, -1};
    for (int k = 1; k <= 20; k++) begin
      step();
      for (int i = 0; i < 2; i++) if (!busy_o[i] && n[i] < 0) n[i] = k;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (n[i] != dep[i]) begin
        errors++; $display("FAIL clear_busy_len inst%0d: got %0d cycles exp %0d", i, n[i], dep[i]);
      end
    end
    for (int a = 0; a < 16; a++) begin
      rd_en1 = 1; rd_addr1 = 4'(a); rd_en2 = 1; rd_addr2 = 4'(a);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({v1[i], d1[i], d2[i]} !== {1'b1, 4'h0, 4'h0}) begin
          errors++; $display("FAIL clear_read inst%0d a=%0d: got v1=%b d1=%h d2=%h exp v=1 d=0", i, a, v1[i], d1[i], d2[i]);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    int n;
    idle();
    for (int a = 0; a < 16; a++) begin
      wr_en = 1; wr_addr = 4'(a); wr_data = 4'($urandom_range(1, 15));
      step();
    end
    wr_en = 0; clr_req = 1;
    step();
    clr_req = 0;
    for (int k = 0; k < 7; k++) step();
    reset = 1;
    step();
    reset = 0;
    n = -1;
    for (int k = 1; k <= 22; k++) begin
      if (left[0] > 0) begin
        wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 4'($urandom);
        rd_en1 = 1'($urandom); rd_addr1 = 4'($urandom); rd_en2 = 1; rd_addr2 = 4'($urandom);
        clr_req = 1'($urandom);
      end else idle();
      step();
      checks++;
      if ({busy_o[0], v1[0], d1[0], v2[0], d2[0]} !== {e_busy[0], e_v1[0], e_d1[0], e_v2[0], e_d2[0]}) begin
        errors++; $display("FAIL reset_mid_cycle k=%0d: got b=%b v1=%b d1=%h v2=%b d2=%h exp b=%b v1=%b d1=%h v2=%b d2=%h", k, busy_o[0], v1[0], d1[0], v2[0], d2[0], e_busy[0], e_v1[0], e_d1[0], e_v2[0], e_d2[0]);
      end
      if (!busy_o[0] && n < 0) n = k;
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL reset_mid_busy_len: got %0d cycles exp 16", n);
    end
    idle();
    for (int a = 0; a < 16; a++) begin
      rd_en1 = 1; rd_addr1 = 4'(a);
      step();
      checks++;
      if ({v1[0], d1[0]} !== {1'b1, 4'h0}) begin
        errors++; $display("FAIL reset_mid_read a=%0d: got v1=%b d1=%h exp v=1 d=0", a, v1[0], d1[0]);
      end
    end
    idle();
  endtask

  task automatic test_oob();
    idle();
    wr_en = 1; wr_addr = 4'd12; wr_data = 4'h5;
    step();
    wr_en = 0; rd_en1 = 1; rd_addr1 = 4'd12;
    step();
    checks++;
    if ({v1[1], d1[1]} !== {1'b1, 4'h0}) begin
      errors++; $display("FAIL oob_read d10: got v1=%b d1=%h exp v=1 d=0", v1[1], d1[1]);
    end
    checks++;
    if ({v1[0], d1[0]} !== {1'b1, 4'h5}) begin
      errors++; $display("FAIL oob_inrange d16: got v1=%b d1=%h exp v=1 d=5", v1[0], d1[0]);
    end
    for (int a = 0; a < 10; a++) begin
      rd_en1 = 1; rd_addr1 = 4'(a); rd_en2 = 1; rd_addr2 = 4'(a + 6);
      step();
      checks++;
      if ({v1[1], d1[1], v2[1], d2[1]} !== {e_v1[1], e_d1[1], e_v2[1], e_d2[1]}) begin
        errors++; $display("FAIL oob_others d10 a=%0d: got v1=%b d1=%h v2=%b d2=%h exp v1=%b d1=%h v2=%b d2=%h", a, v1[1], d1[1], v2[1], d2[1], e_v1[1], e_d1[1], e_v2[1], e_d2[1]);
      end
    end
    idle();
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      clr_req = ($urandom_range(0, 59) == 0);
      wr_en = 1'($urandom); wr_addr = 4'($urandom); wr_data = 4'($urandom);
      rd_en1 = 1'($urandom); rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
      rd_en2 = 1'($urandom); rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : 4'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({busy_o[i], v1[i], d1[i], v2[i], d2[i]} !== {e_busy[i], e_v1[i], e_d1[i], e_v2[i], e_d2[i]}) begin
          errors++; $display("FAIL random inst%0d k=%0d: got b=%b v1=%b d1=%h v2=%b d2=%h exp b=%b v1=%b d1=%h v2=%b d2=%h", i, k, busy_o[i], v1[i], d1[i], v2[i], d2[i], e_busy[i], e_v1[i], e_d1[i], e_v2[i], e_d2[i]);
        end
      end
    end
    reset = 0;
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_clear();
    test_reset_mid();
    test_oob();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
